// File: rtl/hci_filler_pkg.sv
// hci_filler_pkg: FSM state encodings, fill-mode encodings and the LFSR step shared by the filler.
package hci_filler_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_WRITE  = 3'd1;
  localparam state_t S_WDRAIN = 3'd2;
  localparam state_t S_READ   = 3'd3;
  localparam state_t S_RDRAIN = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam logic [1:0] FILL_INCR  = 2'd0;
  localparam logic [1:0] FILL_LFSR  = 2'd1;
  localparam logic [1:0] FILL_CONST = 2'd2;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
  endfunction
endpackage

// File: rtl/hci_filler_patgen.sv
// hci_filler_patgen: registered fill-pattern generator; data_o holds the current word, load restarts at word 0, adv steps one word.
module hci_filler_patgen import hci_filler_pkg::*; #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    mode_i,
  input  logic [31:0]   seed_i,
  input  logic [DW-1:0] const_i,
  input  logic          load_i,
  input  logic          adv_i,
  output logic [DW-1:0] data_o
);
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [DW-1:0] data_q, rep;
  always_comb begin
    idx_d = load_i ? '0 : idx_q + 1'b1;
    lfsr_d = load_i ? (seed_i == '0 ? 32'h1 : seed_i) : lfsr_next(lfsr_q);
    rep = DW'({(DW + 31) / 32{lfsr_d}});
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      lfsr_q <= '0;
      data_q <= '0;
    end else if (load_i || adv_i) begin
      idx_q <= idx_d;
      lfsr_q <= lfsr_d;
      data_q <= mode_i == FILL_LFSR ? rep : mode_i == FILL_CONST ? const_i : DW'(idx_d);
    end
  end
  assign data_o = data_q;
endmodule

// File: rtl/hci_tcdm_filler.sv
// hci_tcdm_filler: TCDM fill engine with optional readback compare and bounded outstanding requests.
// Define HCI_FILLER_ERR_LOG_EN to keep the mismatch counter and first-error address register.
module hci_tcdm_filler import hci_filler_pkg::*; #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              verify_i,
  input  logic [AW-1:0]     base_addr_i,
  input  logic [CNT_W-1:0]  n_words_i,
  input  logic [DW-1:0]     const_data_i,
  input  logic [31:0]       seed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [AW-1:0]     first_err_addr_o,
  output logic              tcdm_req_o,
  input  logic              tcdm_gnt_i,
  output logic [AW-1:0]     tcdm_add_o,
  output logic              tcdm_wen_o,
  output logic [DW-1:0]     tcdm_data_o,
  output logic [DW/8-1:0]   tcdm_be_o,
  input  logic [DW-1:0]     tcdm_r_data_i,
  input  logic              tcdm_r_valid_i,
  output logic              tcdm_r_ready_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  state_t state_q, state_d;
  logic [OW-1:0] out_q, out_d;
  logic [CNT_W-1:0] n_q, iss_q;
  logic [AW-1:2] base_q;
  logic [AW-1:0] add_q, ld_add;
  logic [1:0] mode_q, mode_s;
  logic [DW-1:0] const_q, const_s, exp_data;
  logic [31:0] seed_q, seed_s;
  logic verify_q, req_q, req_d, wen_q, err_q;
  logic fire, last, retire, start_acc, ld, rd_rsp, mism;
  always_comb begin
    fire = req_q & tcdm_gnt_i;
    retire = tcdm_r_valid_i && out_q != '0;
    out_d = clear_i ? '0 : out_q + OW'(fire) - OW'(retire);
    last = fire && iss_q == n_q - 1'b1;
    start_acc = !clear_i && state_q == S_IDLE && start_i;
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = n_words_i == '0 ? S_DONE : S_WRITE;
      S_WRITE:  if (last) state_d = S_WDRAIN;
      S_WDRAIN: if (out_q == '0) state_d = verify_q ? S_READ : S_DONE;
      S_READ:   if (last) state_d = S_RDRAIN;
      S_RDRAIN: if (out_q == '0) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    if (clear_i) state_d = S_IDLE;
    ld = state_d != state_q && (state_d == S_WRITE || state_d == S_READ);
    req_d = (state_d == S_WRITE || state_d == S_READ) && out_d < OW'(MAX_OUTSTANDING);
    // The start edge loads word 0 straight from the inputs; later phases reuse latched config.
    mode_s = state_q == S_IDLE ? mode_i : mode_q;
    const_s = state_q == S_IDLE ? const_data_i : const_q;
    seed_s = state_q == S_IDLE ? seed_i : seed_q;
    ld_add = {state_q == S_IDLE ? base_addr_i[AW-1:2] : base_q, 2'b00};
    rd_rsp = tcdm_r_valid_i && (state_q == S_READ || state_q == S_RDRAIN);
    mism = rd_rsp && tcdm_r_data_i != exp_data;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      out_q <= '0;
      n_q <= '0;
      iss_q <= '0;
      base_q <= '0;
      add_q <= '0;
      mode_q <= '0;
      const_q <= '0;
      seed_q <= '0;
      verify_q <= 1'b0;
      req_q <= 1'b0;
      wen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      req_q <= req_d;
      if (start_acc) begin
        n_q <= n_words_i;
        base_q <= base_addr_i[AW-1:2];
        mode_q <= mode_i;
        const_q <= const_data_i;
        seed_q <= seed_i;
        verify_q <= verify_i;
      end
      if (ld) begin
        add_q <= ld_add;
        iss_q <= '0;
        wen_q <= state_q != S_IDLE;
      end else if (fire) begin
        add_q <= add_q + AW'(4);
        iss_q <= iss_q + 1'b1;
      end
      err_q <= start_acc ? 1'b0 : err_q | mism;
    end
  end
  hci_filler_patgen #(.DW(DW), .CNT_W(CNT_W)) u_issue (
    .clk_i, .rst_i, .mode_i(mode_s), .seed_i(seed_s), .const_i(const_s),
    .load_i(ld), .adv_i(fire), .data_o(tcdm_data_o)
  );
  hci_filler_patgen #(.DW(DW), .CNT_W(CNT_W)) u_cmp (
    .clk_i, .rst_i, .mode_i(mode_s), .seed_i(seed_s), .const_i(const_s),
    .load_i(ld), .adv_i(rd_rsp), .data_o(exp_data)
  );
`ifdef HCI_FILLER_ERR_LOG_EN
  logic [CNT_W-1:0] err_cnt_q;
  logic [AW-1:0] first_q, rsp_add_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
      first_q <= '0;
      rsp_add_q <= '0;
    end else begin
      if (ld) rsp_add_q <= ld_add;
      else if (rd_rsp) rsp_add_q <= rsp_add_q + AW'(4);
      if (start_acc) begin
        err_cnt_q <= '0;
        first_q <= '0;
      end else if (mism) begin
        err_cnt_q <= err_cnt_q + CNT_W'(~&err_cnt_q);
        if (!err_q) first_q <= rsp_add_q;
      end
    end
  end
  assign err_cnt_o = err_cnt_q;
  assign first_err_addr_o = first_q;
`else
  assign err_cnt_o = '0;
  assign first_err_addr_o = '0;
`endif
  assign busy_o = state_q != S_IDLE;
  assign done_o = state_q == S_DONE;
  assign err_o = err_q;
  assign tcdm_req_o = req_q;
  assign tcdm_add_o = add_q;
  assign tcdm_wen_o = wen_q;
  assign tcdm_be_o = '1;
  assign tcdm_r_ready_o = 1'b1;
endmodule

// File: tb/tb_hci_tcdm_filler.sv
// tb_hci_tcdm_filler: directed fill/verify scenarios against a TCDM memory model with a request scoreboard.
module tb_hci_tcdm_filler;
  localparam int AW = 32, DW = 32, MO = 4, CW = 16;
  logic clk = 0, rst = 1;
  logic clear_i = 0, start_i = 0, verify_i = 0;
  logic [1:0] mode_i = 0;
  logic [AW-1:0] base_i = 0;
  logic [CW-1:0] n_i = 0;
  logic [DW-1:0] cdata_i = 0;
  logic [31:0] seed_i = 0;
  logic busy_o, done_o, err_o, req_o, wen_o, r_ready_o;
  logic [CW-1:0] err_cnt_o;
  logic [AW-1:0] first_o, add_o;
  logic [DW-1:0] data_o;
  logic [DW/8-1:0] be_o;
  logic gnt_i = 0, r_valid_i = 0;
  logic [DW-1:0] r_data_i = 0;

  hci_tcdm_filler #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_i), .start_i(start_i), .mode_i(mode_i),
    .verify_i(verify_i), .base_addr_i(base_i), .n_words_i(n_i), .const_data_i(cdata_i),
    .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_o), .tcdm_req_o(req_o), .tcdm_gnt_i(gnt_i), .tcdm_add_o(add_o),
    .tcdm_wen_o(wen_o), .tcdm_data_o(data_o), .tcdm_be_o(be_o), .tcdm_r_data_i(r_data_i),
    .tcdm_r_valid_i(r_valid_i), .tcdm_r_ready_o(r_ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic wen; logic [31:0] data; logic chk;} req_t;
  typedef struct {int due; logic [31:0] data; logic bad;} rsp_t;
  req_t exp_q[$];
  rsp_t pend_q[$];
  logic [31:0] mem [logic [31:0]];
  int cyc = 0, lat = 2, tb_out = 0, peak = 0, done_cnt = 0, done_cyc = -1, fires = 0;
  int first_fire = -1, last_wfire = -1, bad_cyc = -1, err_rise = -1, st = 0;
  int checks = 0, errors = 0;
  logic rand_gnt = 0, hold_gnt = 0, p_stall = 0, p_wen = 0, err_prev = 0;
  logic [31:0] corrupt_addr = 32'h1, p_add = 0, p_data = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // TCDM model and request monitor: all DUT sampling and grant/response driving on the falling edge.
  always @(negedge clk) begin
    logic g;
    rsp_t r;
    req_t e;
    g = !hold_gnt && (!rand_gnt || $urandom_range(0, 2) != 0);
    gnt_i = g;
    r_valid_i = 0;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      r = pend_q.pop_front();
      r_valid_i = 1;
      r_data_i = r.data;
      tb_out--;
      if (r.bad) bad_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_o && !err_prev) err_rise = cyc;
    err_prev = err_o;
    if (req_o && p_stall) begin
      chk("stall_add", add_o, p_add);
      chk("stall_wen", wen_o, p_wen);
      chk("stall_data", data_o, p_data);
    end
    p_stall = req_o && !g;
    p_add = add_o;
    p_wen = wen_o;
    p_data = data_o;
    if (req_o && g) begin
      fires++;
      if (first_fire < 0) first_fire = cyc;
      if (!wen_o) last_wfire = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got add %0h wen %0b, required no request", add_o, wen_o);
      end else begin
        e = exp_q.pop_front();
        chk("req_add", add_o, e.addr);
        chk("req_wen", wen_o, e.wen);
        if (e.chk) chk("req_data", data_o, e.data);
      end
      if (!wen_o) mem[add_o] = data_o;
      pend_q.push_back('{cyc + lat, !wen_o ? 32'h0 : add_o == corrupt_addr ? ~mem[add_o] : mem[add_o],
                         wen_o && add_o == corrupt_addr});
      tb_out++;
      if (tb_out > peak) peak = tb_out;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [1:0] m, input logic [31:0] base, input int n, input logic v,
                        input logic [31:0] cd, input logic [31:0] sd, input int l, input logic rg);
    logic [31:0] s, a, d;
    for (int ph = 0; ph < (v ? 2 : 1); ph++) begin
      s = sd == 0 ? 32'h1 : sd;
      a = {base[31:2], 2'b00};
      for (int i = 0; i < n; i++) begin
        d = m == 2'd1 ? s : m == 2'd2 ? cd : 32'(i);
        exp_q.push_back('{a, 1'(ph), d, ph == 0});
        a += 4;
        s = step(s);
      end
    end
    lat = l;
    rand_gnt = rg;
    done_cnt = 0;
    fires = 0;
    first_fire = -1;
    last_wfire = -1;
    peak = 0;
    bad_cyc = -1;
    err_rise = -1;
    mode_i = m;
    base_i = base;
    n_i = CW'(n);
    verify_i = v;
    cdata_i = cd;
    seed_i = sd;
    start_i = 1;
    st = cyc;
    tick();
    start_i = 0;
  endtask

  task automatic finish(input string name);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      tick();
      t++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt != 0), 1);
    tick(3);
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_reqs_left"}, exp_q.size(), 0);
    chk({name, "_idle"}, busy_o, 0);
  endtask

  task automatic drain();
    int t = 0;
    while (pend_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk("drain_responses", pend_q.size(), 0);
    tick(3);
  endtask

  initial begin
    int t;
    tick(2);
    chk("rst_req", req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    chk("rst_first", first_o, 0);
    chk("rst_add", add_o, 0);
    chk("rst_wen", wen_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_be", be_o, 4'hF);
    chk("rst_rready", r_ready_o, 1);
    rst = 0;
    tick(2);
    chk("idle_req", req_o, 0);

    launch(2'd0, 32'h100, 8, 1, 0, 0, 2, 0);
    finish("incr");
    chk("incr_first_req", first_fire, st + 1);
    chk("incr_back_to_back", last_wfire, st + 8);
    chk("incr_err", err_o, 0);

    launch(2'd1, 32'h1000, 16, 1, 0, 0, 2, 1);
    finish("lfsr");
    chk("lfsr_peak_le_max", 64'(peak <= MO), 1);
    chk("lfsr_err", err_o, 0);

    launch(2'd0, 32'h500, 6, 0, 0, 0, 7, 0);
    finish("cap");
    chk("cap_peak", peak, MO);

    corrupt_addr = 32'h8;
    launch(2'd2, 32'h0, 4, 1, 32'hDEADBEEF, 0, 2, 0);
    finish("const");
    corrupt_addr = 32'h1;
    chk("const_err", err_o, 1);
    chk("const_err_latency", err_rise, bad_cyc + 1);
`ifdef HCI_FILLER_ERR_LOG_EN
    chk("const_err_cnt", err_cnt_o, 1);
    chk("const_first_addr", first_o, 32'h8);
`else
    chk("const_err_cnt", err_cnt_o, 0);
    chk("const_first_addr", first_o, 0);
`endif

    launch(2'd0, 32'h40, 0, 1, 0, 0, 2, 0);
    finish("zero");
    chk("zero_done_cycle", done_cyc, st + 1);
    chk("zero_no_req", fires, 0);
    chk("zero_err_cleared", err_o, 0);

    launch(2'd0, 32'hFFFFFFF8, 4, 0, 0, 0, 2, 0);
    finish("wrap");

    launch(2'd0, 32'h400, 8, 0, 0, 0, 2, 0);
    tick(3);
    rst = 1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_req", req_o, 0);
    chk("arst_add", add_o, 0);
    drain();
    rst = 0;
    exp_q.delete();
    tick(2);

    launch(2'd0, 32'h300, 8, 1, 0, 0, 8, 0);
    t = 0;
    while (!(busy_o && wen_o && tb_out == 3) && t < 500) begin
      tick();
      t++;
    end
    chk("clear_reached_3_outstanding", tb_out, 3);
    hold_gnt = 1;
    clear_i = 1;
    tick();
    clear_i = 0;
    hold_gnt = 0;
    exp_q.delete();
    chk("clear_idle_next", busy_o, 0);
    chk("clear_no_done", done_o, 0);
    drain();
    chk("clear_done_never", done_cnt, 0);
    chk("clear_still_idle", busy_o, 0);

    launch(2'd0, 32'h200, 4, 1, 0, 0, 2, 0);
    finish("after_clear");
    chk("after_clear_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule
